// File: rtl/hazard_pkg.sv
// Shared constants, scoreboard entry type and small helpers for the MIPS hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;
  localparam logic [1:0] TNEW_LINK = 2'd0;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } sb_entry_t;

  function automatic logic [1:0] dec_sat0(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Register $0 is hard-wired, so it never matches a pending write.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] wa);
    return (src != 5'd0) && (src == wa);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO multiply/divide busy counter: loads on an accepted start, counts down to zero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_accept,
  output logic o_busy
);

  logic [3:0] r_cnt;
  logic [3:0] w_load_val;

  // Select the operation latency to load.
  always_comb begin
    w_load_val = 4'd0;
    if (i_is_div) begin
      w_load_val = 4'(DIV_CYCLES);
    end else begin
      w_load_val = 4'(MULT_CYCLES);
    end
  end

  // Counter: a start only loads when the issuing instruction leaves D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (i_start && i_accept) begin
      r_cnt <= w_load_val;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_busy = (r_cnt != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard controller: Tuse/Tnew scoreboard stalls, D/E forwarding selects
// and HI/LO busy interlock.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] TuseRsD,
  input  logic [1:0] TuseRtD,
  input  logic [4:0] waD,
  input  logic [1:0] TnewD,
  input  logic       mdStartD,
  input  logic       mdDivD,
  input  logic       mdUseD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  output logic       stallF,
  output logic       stallD,
  output logic       clrE,
  output logic [1:0] fwdRsD,
  output logic [1:0] fwdRtD,
  output logic [1:0] fwdRsE,
  output logic [1:0] fwdRtE,
  output logic       mdBusy
);

  sb_entry_t  r_sb_e;
  sb_entry_t  r_sb_m;
  logic [4:0] r_wa_w;

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;
  logic w_md_busy;

  function automatic logic operand_stall(input logic [4:0] src, input logic [1:0] tuse,
                                         input sb_entry_t e, input sb_entry_t m);
    logic s;
    s = 1'b0;
    if (tuse != TUSE_NONE) begin
      s = (reg_hit(src, e.wa) && (tuse < e.tnew)) || (reg_hit(src, m.wa) && (tuse < m.tnew));
    end else begin
      s = 1'b0;
    end
    return s;
  endfunction

  function automatic logic [1:0] fwd_d_sel(input logic [4:0] src, input sb_entry_t e,
                                           input sb_entry_t m, input logic [4:0] wa_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_hit(src, e.wa) && (e.tnew == 2'd0)) begin
      sel = FWD_E;
    end else if (reg_hit(src, m.wa) && (m.tnew == 2'd0)) begin
      sel = FWD_M;
    end else if (reg_hit(src, wa_w)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input sb_entry_t m,
                                           input logic [4:0] wa_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_hit(src, m.wa) && (m.tnew == 2'd0)) begin
      sel = FWD_M;
    end else if (reg_hit(src, wa_w)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Stall decision from the scoreboard and the D-stage demands.
  always_comb begin
    w_stall_rs = operand_stall(rsD, TuseRsD, r_sb_e, r_sb_m);
    w_stall_rt = operand_stall(rtD, TuseRtD, r_sb_e, r_sb_m);
    w_stall_md = mdUseD && w_md_busy;
    w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
  end

  // Forwarding selects for both D and E operands.
  always_comb begin
    fwdRsD = fwd_d_sel(rsD, r_sb_e, r_sb_m, r_wa_w);
    fwdRtD = fwd_d_sel(rtD, r_sb_e, r_sb_m, r_wa_w);
    fwdRsE = fwd_e_sel(rsE, r_sb_m, r_wa_w);
    fwdRtE = fwd_e_sel(rtE, r_sb_m, r_wa_w);
  end

  // Scoreboard shift; a stalled D instruction leaves a bubble in E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sb_e.wa   <= 5'd0;
      r_sb_e.tnew <= 2'd0;
      r_sb_m.wa   <= 5'd0;
      r_sb_m.tnew <= 2'd0;
      r_wa_w      <= 5'd0;
    end else begin
      r_wa_w      <= r_sb_m.wa;
      r_sb_m.wa   <= r_sb_e.wa;
      r_sb_m.tnew <= dec_sat0(r_sb_e.tnew);
      if (w_stall) begin
        r_sb_e.wa   <= 5'd0;
        r_sb_e.tnew <= 2'd0;
      end else begin
        r_sb_e.wa   <= waD;
        r_sb_e.tnew <= TnewD;
      end
    end
  end

  md_busy_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy (
    .clk     (clk),
    .reset   (reset),
    .i_start (mdStartD),
    .i_is_div(mdDivD),
    .i_accept(!w_stall),
    .o_busy  (w_md_busy)
  );

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign clrE   = w_stall;
  assign mdBusy = w_md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference pipeline model predicts every cycle's outputs.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rsD, rtD, waD, rsE, rtE;
  logic [1:0] TuseRsD, TuseRtD, TnewD;
  logic       mdStartD, mdDivD, mdUseD;
  logic       stallF, stallD, clrE, mdBusy;
  logic [1:0] fwdRsD, fwdRtD, fwdRsE, fwdRtE;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
    .waD(waD), .TnewD(TnewD),
    .mdStartD(mdStartD), .mdDivD(mdDivD), .mdUseD(mdUseD),
    .rsE(rsE), .rtE(rtE),
    .stallF(stallF), .stallD(stallD), .clrE(clrE),
    .fwdRsD(fwdRsD), .fwdRtD(fwdRtD), .fwdRsE(fwdRsE), .fwdRtE(fwdRtE),
    .mdBusy(mdBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int stall;
    int frsd;
    int frtd;
    int frse;
    int frte;
    int busy;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference pipeline state.
  int m_wa_e, m_tn_e, m_wa_m, m_tn_m, m_wa_w, m_cnt;

  // Most recent sampled DUT values, for directed checks.
  int l_stall, l_frsd, l_frse, l_busy;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_blocked(input int src, input int tuse);
    if (src == 0 || tuse == 3) return 0;
    if (src == m_wa_e && tuse < m_tn_e) return 1;
    if (src == m_wa_m && tuse < m_tn_m) return 1;
    return 0;
  endfunction

  function automatic int m_fwd_d(input int src);
    if (src == 0) return 0;
    if (src == m_wa_e && m_tn_e == 0) return 1;
    if (src == m_wa_m && m_tn_m == 0) return 2;
    if (src == m_wa_w) return 3;
    return 0;
  endfunction

  function automatic int m_fwd_e(input int src);
    if (src == 0) return 0;
    if (src == m_wa_m && m_tn_m == 0) return 2;
    if (src == m_wa_w) return 3;
    return 0;
  endfunction

  task automatic model_clear();
    m_wa_e = 0; m_tn_e = 0; m_wa_m = 0; m_tn_m = 0; m_wa_w = 0; m_cnt = 0;
  endtask

  // One D-stage cycle: drive, predict, sample at negedge, then advance the model at posedge.
  task automatic cyc(input string tag, input int rs, input int trs, input int rt, input int trt,
                     input int wa, input int tnew, input int mds, input int mdd, input int mdu,
                     input int rse, input int rte);
    exp_t e, g;
    rsD = 5'(rs); TuseRsD = 2'(trs); rtD = 5'(rt); TuseRtD = 2'(trt);
    waD = 5'(wa); TnewD = 2'(tnew);
    mdStartD = 1'(mds); mdDivD = 1'(mdd); mdUseD = 1'(mdu);
    rsE = 5'(rse); rtE = 5'(rte);
    e.stall = (m_blocked(rs, trs) || m_blocked(rt, trt) || (mdu != 0 && m_cnt != 0)) ? 1 : 0;
    e.frsd = m_fwd_d(rs);
    e.frtd = m_fwd_d(rt);
    e.frse = m_fwd_e(rse);
    e.frte = m_fwd_e(rte);
    e.busy = (m_cnt != 0) ? 1 : 0;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    l_stall = int'(stallD); l_frsd = int'(fwdRsD); l_frse = int'(fwdRsE); l_busy = int'(mdBusy);
    check_eq({tag, ".stallF"}, int'(stallF), g.stall);
    check_eq({tag, ".stallD"}, int'(stallD), g.stall);
    check_eq({tag, ".clrE"},   int'(clrE),   g.stall);
    check_eq({tag, ".fwdRsD"}, int'(fwdRsD), g.frsd);
    check_eq({tag, ".fwdRtD"}, int'(fwdRtD), g.frtd);
    check_eq({tag, ".fwdRsE"}, int'(fwdRsE), g.frse);
    check_eq({tag, ".fwdRtE"}, int'(fwdRtE), g.frte);
    check_eq({tag, ".mdBusy"}, int'(mdBusy), g.busy);
    @(posedge clk);
    m_wa_w = m_wa_m;
    m_wa_m = m_wa_e;
    m_tn_m = (m_tn_e > 0) ? m_tn_e - 1 : 0;
    if (g.stall != 0) begin
      m_wa_e = 0; m_tn_e = 0;
    end else begin
      m_wa_e = wa; m_tn_e = tnew;
    end
    if (mds != 0 && g.stall == 0) m_cnt = (mdd != 0) ? 10 : 5;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    rsD = 5'd0; rtD = 5'd0; TuseRsD = 2'd3; TuseRtD = 2'd3; waD = 5'd0; TnewD = 2'd0;
    mdStartD = 1'b0; mdDivD = 1'b0; mdUseD = 1'b0; rsE = 5'd0; rtE = 5'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle(1);
    check_eq("rst_stall", l_stall, 0);
    check_eq("rst_busy", l_busy, 0);

    // lw $8 then dependent addu
    cyc("lw8", 29, 1, 0, 3, 8, 2, 0, 0, 0, 0, 0);
    cyc("addu_a", 8, 1, 9, 1, 10, 1, 0, 0, 0, 29, 0);
    check_eq("lu_stall1", l_stall, 1);
    cyc("addu_b", 8, 1, 9, 1, 10, 1, 0, 0, 0, 0, 0);
    check_eq("lu_stall2", l_stall, 0);
    cyc("addu_e", 0, 3, 0, 3, 0, 0, 0, 0, 0, 8, 9);
    check_eq("lu_fwdRsE", l_frse, 3);
    idle(3);

    // ALU result into branch
    cyc("addu9", 1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 0);
    cyc("beq_a", 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("ab_stall", l_stall, 1);
    cyc("beq_b", 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("ab_nostall", l_stall, 0);
    check_eq("ab_fwdRsD", l_frsd, 2);
    idle(3);

    // Same with one nop between
    cyc("addu9n", 1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 0);
    idle(1);
    cyc("beq_n", 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("abn_stall", l_stall, 0);
    check_eq("abn_fwdRsD", l_frsd, 2);
    idle(3);

    // jal then jr $31
    cyc("jal", 0, 3, 0, 3, 31, 0, 0, 0, 0, 0, 0);
    cyc("jr", 31, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("jr_stall", l_stall, 0);
    check_eq("jr_fwdRsD", l_frsd, 1);
    idle(3);

    // Load then branch: two stall cycles
    cyc("lw8b", 29, 1, 0, 3, 8, 2, 0, 0, 0, 0, 0);
    cyc("lb_a", 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("lb_stall1", l_stall, 1);
    cyc("lb_b", 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("lb_stall2", l_stall, 1);
    cyc("lb_c", 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("lb_stall3", l_stall, 0);
    check_eq("lb_fwdRsD", l_frsd, 3);
    idle(3);

    // $0 sources never stall or forward
    cyc("lw0", 29, 1, 0, 3, 0, 2, 0, 0, 0, 0, 0);
    cyc("use0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check_eq("r0_stall", l_stall, 0);
    check_eq("r0_fwdRsD", l_frsd, 0);
    idle(3);

    // Stalled mult start must not load the counter
    cyc("lw8c", 29, 1, 0, 3, 8, 2, 0, 0, 0, 0, 0);
    cyc("mult_a", 8, 1, 0, 3, 0, 0, 1, 0, 1, 0, 0);
    check_eq("ms_stall", l_stall, 1);
    cyc("mult_b", 8, 1, 0, 3, 0, 0, 1, 0, 1, 0, 0);
    check_eq("ms_busy", l_busy, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc("mflo_m", 0, 3, 0, 3, 2, 1, 0, 0, 1, 0, 0);
      if (l_stall == 0) break;
      n++;
    end
    check_eq("mult_stall_cycles", n, 5);
    idle(2);

    // div accepted then mflo
    cyc("div", 4, 1, 5, 1, 0, 0, 1, 1, 1, 0, 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc("mflo_d", 0, 3, 0, 3, 2, 1, 0, 0, 1, 0, 0);
      if (l_stall == 0) break;
      n++;
    end
    check_eq("div_stall_cycles", n, 10);
    check_eq("div_busy_release", l_busy, 0);
    idle(3);

    // Asynchronous reset mid-divide with counter at 7
    cyc("div2", 4, 1, 5, 1, 0, 0, 1, 1, 1, 0, 0);
    cyc("addu5", 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    idle(2);
    rsD = 5'd5; TuseRsD = 2'd0; rsE = 5'd5; mdUseD = 1'b1;
    #1;
    check_eq("pre_rst_stall", int'(stallD), 1);
    check_eq("pre_rst_busy", int'(mdBusy), 1);
    check_eq("pre_rst_fwdRsD", int'(fwdRsD), 3);
    reset = 1'b1;
    #1;
    check_eq("arst_stall", int'(stallD), 0);
    check_eq("arst_clrE", int'(clrE), 0);
    check_eq("arst_busy", int'(mdBusy), 0);
    check_eq("arst_fwdRsD", int'(fwdRsD), 0);
    check_eq("arst_fwdRsE", int'(fwdRsE), 0);
    reset = 1'b0;
    rsD = 5'd0; TuseRsD = 2'd3; rsE = 5'd0; mdUseD = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      int r0, r1, r2, r3, r4;
      r0 = $urandom_range(0, 4); r1 = $urandom_range(0, 4); r2 = $urandom_range(0, 4);
      r3 = $urandom_range(0, 4); r4 = $urandom_range(0, 4);
      cyc("rnd",
          (r0 == 4) ? 31 : r0, $urandom_range(0, 3),
          (r1 == 4) ? 31 : r1, $urandom_range(0, 3),
          (r2 == 4) ? 31 : r2, $urandom_range(0, 2),
          ($urandom_range(0, 11) == 0) ? 1 : 0, $urandom_range(0, 1),
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          (r3 == 4) ? 31 : r3, (r4 == 4) ? 31 : r4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
